backward_recursion_flp: RTL

Anti-causal counterpart of the forward floating-point recursion in the control-bounded filter estimator. It collects input samples in forward time order into a ping-pong batch buffer, then replays each completed batch in reverse order through a complex first-order recursion: state = state·factor + x. Its output feeds the same float summation stage as the forward recursions, so forward and backward filter contributions can be combined batch by batch.

---
 rtl/backward_recursion_flp_pkg.sv | 127 ++++++++++++
 rtl/backward_recursion_flp_batch_lifo_buffer.sv | 54 +++++
 rtl/backward_recursion_flp.sv | 98 +++++++++
 3 files changed

// File: rtl/backward_recursion_flp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// backward_recursion_flp_pkg : float/complex types, FSM states, shared float ops
// Rev 1.0
// ----------------------------------------------------------------------------
package backward_recursion_flp_pkg;

  localparam int F_EXP  = 8;
  localparam int F_MANT = 23;
  localparam int F_BIAS = (1 << (F_EXP - 1)) - 1;
  localparam int F_EMAX = (1 << F_EXP) - 1;
  localparam int GRD    = F_MANT + 2;
  localparam int SW     = F_MANT + GRD + 2;
  localparam int PW     = 2 * F_MANT + 2;

  typedef struct packed {
    logic              sign;
    logic [F_EXP-1:0]  expo;
    logic [F_MANT-1:0] mant;
  } float_t;

  typedef struct packed {
    float_t re;
    float_t im;
  } complex_t;

  typedef enum logic {IDLE = 1'b0, REPLAY = 1'b1} state_e;

  typedef enum logic {FPU_ADD = 1'b0, FPU_SUB = 1'b1} fpu_op_e;

  // Subnormal results flush to zero, exponent overflow saturates to infinity.
  function automatic float_t fp_pack(logic sgn, int e, logic [F_MANT-1:0] m);
    float_t r;
    r = '0;
    if (e >= F_EMAX) begin
      r.sign = sgn;
      r.expo = F_EXP'(F_EMAX);
    end else if (e > 0) begin
      r.sign = sgn;
      r.expo = F_EXP'(e);
      r.mant = m;
    end
    return r;
  endfunction

  function automatic float_t fix2float(logic signed [63:0] v, int frac_bits);
    logic [63:0] mag;
    logic [63:0] norm;
    int          p;
    float_t      r;
    mag = v[63] ? -v : v;
    r   = '0;
    p   = 0;
    if (mag != '0) begin
      for (int i = 0; i < 64; i++) begin
        if (mag[i]) p = i;
      end
      norm = mag << (63 - p);
      r    = fp_pack(v[63], p - frac_bits + F_BIAS, norm[62 -: F_MANT]);
    end
    return r;
  endfunction

  function automatic float_t fp_mul(float_t a, float_t b);
    logic [PW-1:0] prod;
    logic          sgn;
    int            e;
    float_t        r;
    sgn  = a.sign ^ b.sign;
    prod = PW'({1'b1, a.mant}) * PW'({1'b1, b.mant});
    e    = int'(a.expo) + int'(b.expo) - F_BIAS;
    if (a.expo == '0 || b.expo == '0) r = '0;
    else if (prod[PW-1]) r = fp_pack(sgn, e + 1, prod[PW-2 -: F_MANT]);
    else r = fp_pack(sgn, e, prod[PW-3 -: F_MANT]);
    return r;
  endfunction

  function automatic float_t fp_addsub(float_t a, float_t b, fpu_op_e op);
    float_t        x, y, t, r;
    logic [SW-1:0] mx, my, s, norm;
    int            d, p;
    x = a;
    y = b;
    if (op == FPU_SUB) y.sign = ~b.sign;
    // Order operands by magnitude so the result takes the larger operand's sign.
    if ({y.expo, y.mant} > {x.expo, x.mant}) begin
      t = x;
      x = y;
      y = t;
    end
    r = '0;
    if (x.expo == '0) r = '0;
    else if (y.expo == '0) r = x;
    else begin
      d  = int'(x.expo) - int'(y.expo);
      mx = {2'b01, x.mant, {GRD{1'b0}}};
      my = {2'b01, y.mant, {GRD{1'b0}}};
      my = (d >= SW) ? '0 : (my >> d);
      s  = (x.sign == y.sign) ? (mx + my) : (mx - my);
      if (s != '0) begin
        p = 0;
        for (int i = 0; i < SW; i++) begin
          if (s[i]) p = i;
        end
        norm = s << (SW - 1 - p);
        r    = fp_pack(x.sign, int'(x.expo) + p - (F_MANT + GRD), norm[SW-2 -: F_MANT]);
      end
    end
    return r;
  endfunction

  function automatic complex_t cmul(complex_t a, complex_t b);
    complex_t r;
    r.re = fp_addsub(fp_mul(a.re, b.re), fp_mul(a.im, b.im), FPU_SUB);
    r.im = fp_addsub(fp_mul(a.re, b.im), fp_mul(a.im, b.re), FPU_ADD);
    return r;
  endfunction

  function automatic complex_t cadd(complex_t a, complex_t b);
    complex_t r;
    r.re = fp_addsub(a.re, b.re, FPU_ADD);
    r.im = fp_addsub(a.im, b.im, FPU_ADD);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/backward_recursion_flp_batch_lifo_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// batch_lifo_buffer : ping-pong batch store, forward writes and reverse reads
// Rev 1.0
// ----------------------------------------------------------------------------
module batch_lifo_buffer
  import backward_recursion_flp_pkg::*;
#(
  parameter int N = 64
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     wr_en_i,
  input  complex_t wr_data_i,
  input  logic     rd_en_i,
  output logic     swap_o,
  output logic     rd_last_o,
  output complex_t rd_data_o
);

  localparam int AW = $clog2(N);

  complex_t      mem_q [2*N];
  logic [AW-1:0] widx_q;
  logic [AW-1:0] ridx_q;
  logic          wsel_q;

  assign swap_o    = wr_en_i && (widx_q == AW'(N - 1));
  assign rd_last_o = (ridx_q == '0);
  // The read bank is always the one the writer is not using.
  assign rd_data_o = mem_q[{~wsel_q, ridx_q}];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[{wsel_q, widx_q}] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      widx_q <= '0;
      ridx_q <= '0;
      wsel_q <= 1'b0;
    end else begin
      if (wr_en_i) widx_q <= widx_q + AW'(1);
      if (swap_o) begin
        wsel_q <= ~wsel_q;
        ridx_q <= AW'(N - 1);
      end else if (rd_en_i && !rd_last_o) begin
        ridx_q <= ridx_q - AW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/backward_recursion_flp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// backward_recursion_flp : batch-reversed complex float recursion s = s*f + x
// Rev 1.0
// ----------------------------------------------------------------------------
module backward_recursion_flp
  import backward_recursion_flp_pkg::*;
#(
  parameter logic signed [63:0] factorR = 64'sd0,
  parameter logic signed [63:0] factorI = 64'sd0,
  parameter int                 n_int   = 15,
  parameter int                 n_mant  = 48,
  parameter int                 f_exp   = 8,
  parameter int                 f_mant  = 23,
  parameter int                 N       = 64
) (
  input  logic     clk,
  input  logic     rst,
  input  complex_t in,
  input  logic     in_valid,
  input  complex_t loadVal,
  output complex_t out,
  output logic     out_valid,
  output logic     out_last
);

  localparam float_t   FACTOR_RE = fix2float(factorR, n_mant);
  localparam float_t   FACTOR_IM = fix2float(factorI, n_mant);
  localparam complex_t FACTOR    = {FACTOR_RE, FACTOR_IM};
  localparam bit       CFG_OK    = (f_exp == F_EXP) && (f_mant == F_MANT) &&
                                   (n_int + n_mant == 63) && (N >= 2) &&
                                   ((N & (N - 1)) == 0);

  state_e   state_q;
  complex_t acc_q;
  complex_t acc_d;
  complex_t out_q;
  logic     out_valid_q;
  logic     out_last_q;
  complex_t rd_data;
  logic     swap;
  logic     rd_last;
  logic     replay;

  assign replay = (state_q == REPLAY);

  batch_lifo_buffer #(
    .N (N)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_valid),
    .wr_data_i (in),
    .rd_en_i   (replay),
    .swap_o    (swap),
    .rd_last_o (rd_last),
    .rd_data_o (rd_data)
  );

  assign acc_d = cadd(cmul(acc_q, FACTOR), rd_data);

  // A swap landing on the last read reloads the state but still emits entry 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      if (replay) begin
        acc_q       <= acc_d;
        out_q       <= acc_d;
        out_valid_q <= 1'b1;
        out_last_q  <= rd_last;
      end
      if (swap) acc_q <= loadVal;
      case (state_q)
        IDLE:    if (swap) state_q <= REPLAY;
        REPLAY:  if (rd_last && !swap) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // A swap before the last read would hand the writer the bank still replaying.
  a_no_overrun : assert property (@(posedge clk) disable iff (!rst)
                                  (swap && replay) |-> rd_last);
  a_cfg : assert property (@(posedge clk) disable iff (!rst) CFG_OK);

endmodule
`default_nettype wire
